// File: rtl/pixel_writer.sv
`timescale 1ns/1ps
// pixel_writer: accepts (x, y, color) pixels, clips anything off-screen,
// converts the rest to linear framebuffer addresses, buffers them in a small
// FIFO and drains that FIFO to the framebuffer through a req/ack write port.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no write outstanding, mem_req low
// S_REQ  | write presented on mem_addr/mem_data, waiting for mem_ack
module pixel_writer #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_x,
    input  logic [10:0] in_y,
    input  logic [7:0]  in_color,
    output logic        mem_req,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic        busy,
    output logic [19:0] pix_written,
    output logic [19:0] pix_clipped
);

    localparam int LP_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LP_CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [LP_CW-1:0] LP_DEPTH = LP_CW'(FIFO_DEPTH);
    localparam logic [LP_PW-1:0] LP_LAST  = LP_PW'(FIFO_DEPTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [18:0]       r_fifo_addr [FIFO_DEPTH];
    logic [7:0]        r_fifo_color[FIFO_DEPTH];
    logic [LP_PW-1:0]  r_wr_ptr;
    logic [LP_PW-1:0]  r_rd_ptr;
    logic [LP_CW-1:0]  r_count;

    logic              r_mem_req;
    logic [18:0]       r_mem_addr;
    logic [7:0]        r_mem_data;
    logic [19:0]       r_pix_written;
    logic [19:0]       r_pix_clipped;

    logic              w_accept;
    logic              w_in_range;
    logic              w_push;
    logic              w_clip;
    logic              w_pop;
    logic              w_done;
    logic              w_fifo_nempty;
    logic [18:0]       w_addr;

    // Handshake, clipping and address generation on the input side.
    assign in_ready      = (r_count < LP_DEPTH);
    assign w_accept      = in_valid && in_ready;
    assign w_in_range    = ({21'd0, in_x} < 32'(SCREEN_W)) && ({21'd0, in_y} < 32'(SCREEN_H));
    assign w_push        = w_accept && w_in_range;
    assign w_clip        = w_accept && !w_in_range;
    assign w_addr        = 19'(in_y) * 19'(SCREEN_W) + 19'(in_x);
    assign w_fifo_nempty = (r_count != '0);

    assign busy        = w_fifo_nempty || (r_state == S_REQ);
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign mem_data    = r_mem_data;
    assign pix_written = r_pix_written;
    assign pix_clipped = r_pix_clipped;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: stay in S_REQ as long as acks keep finding work.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_fifo_nempty) w_state_nxt = S_REQ;
            S_REQ:  if (mem_ack && !w_fifo_nempty) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: pop when idle with work, or when the current write completes
    // and another entry is waiting (back-to-back issue).
    always_comb begin
        w_pop  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: w_pop = w_fifo_nempty;
            S_REQ: begin
                w_done = mem_ack;
                w_pop  = mem_ack && w_fifo_nempty;
            end
            default: begin
                w_pop  = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= w_addr;
            r_fifo_color[r_wr_ptr] <= in_color;
        end
    end

    // FIFO pointers and occupancy count; count keeps full and empty distinct.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write port registers: loaded on pop, held stable while waiting for ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_mem_req <= (w_state_nxt == S_REQ);
            if (w_pop) begin
                r_mem_addr <= r_fifo_addr[r_rd_ptr];
                r_mem_data <= r_fifo_color[r_rd_ptr];
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_written <= '0;
            r_pix_clipped <= '0;
        end else begin
            if (w_done && (r_pix_written != '1)) r_pix_written <= r_pix_written + 1'b1;
            if (w_clip && (r_pix_clipped != '1)) r_pix_clipped <= r_pix_clipped + 1'b1;
        end
    end

endmodule
